// File: rtl/pd_debug_pkg.sv
// pd_debug_pkg: shared constants and types for the PD debug path.
//   PACKET_SIZE_WIDTH        width of a byte-count increment amount
//   CNT_WIDTH_DEF            default event-counter width
//   BYTE_CNT_WIDTH_DEF       default byte-counter width (33..64)
//   pd_cnt_addr_e            read address map of pd_debug_cnt_cif
//   STAT_*                   bit positions inside the status word
package pd_debug_pkg;

  localparam int PACKET_SIZE_WIDTH  = 14;
  localparam int CNT_WIDTH_DEF      = 32;
  localparam int BYTE_CNT_WIDTH_DEF = 48;

  typedef enum logic [3:0] {
    ADDR_TOTAL   = 4'd0,
    ADDR_F1      = 4'd1,
    ADDR_F2      = 4'd2,
    ADDR_CM      = 4'd3,
    ADDR_F1B_LO  = 4'd4,
    ADDR_F1B_HI  = 4'd5,
    ADDR_F2B_LO  = 4'd6,
    ADDR_F2B_HI  = 4'd7,
    ADDR_CAPTURE = 4'd8,
    ADDR_STATUS  = 4'd9
  } pd_cnt_addr_e;

  // Status word layout; saturated flags occupy STAT_SAT_LSB +: 6 in the
  // order total, f1, f2, cm, f1b, f2b.
  localparam int STAT_VALID_BIT = 0;
  localparam int STAT_F1_BIT    = 1;
  localparam int STAT_F2_BIT    = 2;
  localparam int STAT_SAT_LSB   = 3;
  localparam int STAT_SAT_NUM   = 6;

endpackage

// File: rtl/pd_sat_counter.sv
// pd_sat_counter: saturating accumulator with sticky saturated flag.
//   clk, rstn     clock, synchronous active-low reset
//   inc_en        add inc_amt (zero-extended) this cycle
//   inc_amt       increment amount
//   clr           clear count and flag; a same-cycle increment still lands
//   sat_clr       clear only the saturated flag
//   cnt           current count
//   sat           sticky: count reached all-ones
module pd_sat_counter #(
  parameter int WIDTH     = 32,
  parameter int INC_WIDTH = 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 inc_en,
  input  logic [INC_WIDTH-1:0] inc_amt,
  input  logic                 clr,
  input  logic                 sat_clr,
  output logic [WIDTH-1:0]     cnt,
  output logic                 sat
);

  logic [WIDTH-1:0] cnt_q;
  logic             sat_q;
  logic [WIDTH-1:0] base;
  logic             sat_base;
  logic [WIDTH:0]   sum;
  logic             hit_top;

  // The clear is applied before the add so an increment coinciding with a
  // clear-on-read is not lost.
  always_comb begin
    base     = clr ? '0 : cnt_q;
    sat_base = (clr || sat_clr) ? 1'b0 : sat_q;
    sum      = {1'b0, base} + (WIDTH+1)'(inc_amt);
    hit_top  = sum[WIDTH] || (sum[WIDTH-1:0] == '1);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else if (inc_en) begin
      if (hit_top) begin
        cnt_q <= '1;
        sat_q <= 1'b1;
      end else begin
        cnt_q <= sum[WIDTH-1:0];
        sat_q <= sat_base;
      end
    end else begin
      cnt_q <= base;
      sat_q <= sat_base;
    end
  end

  assign cnt = cnt_q;
  assign sat = sat_q;

endmodule

// File: rtl/pd_debug_cnt_cif.sv
// pd_debug_cnt_cif: event/byte statistics and first-match capture behind the
// PD debug matcher, read through a one-cycle request/acknowledge port.
//   clk, rstn                 clock, synchronous active-low reset
//   dbg2cif_e_*               per-PD increment strobes and capture qualifiers
//   dbg2cif_eq_*_amount       byte increment amount
//   dbg2cif_c_debug_pd_out    debug word latched on the first capture match
//   cfg_clr_on_rd             reads of counters / status clear them
//   cfg_capture_rearm         pulse: drop the captured word and valid flag
//   rd_req, rd_addr           read request (address map in pd_cnt_addr_e)
//   rd_ack, rd_data           registered response, one cycle after rd_req
//   capture_valid_o           a word has been captured
module pd_debug_cnt_cif
  import pd_debug_pkg::*;
#(
  parameter int CNT_WIDTH         = pd_debug_pkg::CNT_WIDTH_DEF,
  parameter int BYTE_CNT_WIDTH    = pd_debug_pkg::BYTE_CNT_WIDTH_DEF,
  parameter int PACKET_SIZE_WIDTH = pd_debug_pkg::PACKET_SIZE_WIDTH
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         dbg2cif_e_debug_pd_total_pd_cnt_inc,
  input  logic                         dbg2cif_e_debug_pd_field1_cnt_inc,
  input  logic                         dbg2cif_e_debug_pd_field2_cnt_inc,
  input  logic                         dbg2cif_e_debug_pd_capture_match_cnt_inc,
  input  logic                         dbg2cif_e_debug_pd_field1_byte_cnt_inc,
  input  logic                         dbg2cif_e_debug_pd_field2_byte_cnt_inc,
  input  logic [PACKET_SIZE_WIDTH-1:0] dbg2cif_eq_debug_pd_field_byte_cnt_inc_amount,
  input  logic                         dbg2cif_e_debug_pd_capture_match_field1,
  input  logic                         dbg2cif_e_debug_pd_capture_match_field2,
  input  logic [31:0]                  dbg2cif_c_debug_pd_out,
  input  logic                         cfg_clr_on_rd,
  input  logic                         cfg_capture_rearm,
  input  logic                         rd_req,
  input  logic [3:0]                   rd_addr,
  output logic                         rd_ack,
  output logic [31:0]                  rd_data,
  output logic                         capture_valid_o
);

  localparam int HI_W = BYTE_CNT_WIDTH - 32;

  logic [CNT_WIDTH-1:0]      tot_cnt, f1_cnt, f2_cnt, cm_cnt;
  logic [BYTE_CNT_WIDTH-1:0] f1b_cnt, f2b_cnt;
  logic [STAT_SAT_NUM-1:0]   sat_vec;
  logic [HI_W-1:0]           f1b_shadow, f2b_shadow;
  logic                      cap_valid, cap_f1, cap_f2;
  logic [31:0]               cap_word;
  logic [31:0]               rd_mux;
  logic                      clr_rd;
  logic                      clr_tot, clr_f1, clr_f2, clr_cm, clr_f1b, clr_f2b, clr_sat;

  always_comb begin
    clr_rd  = rd_req && cfg_clr_on_rd;
    clr_tot = clr_rd && (rd_addr == ADDR_TOTAL);
    clr_f1  = clr_rd && (rd_addr == ADDR_F1);
    clr_f2  = clr_rd && (rd_addr == ADDR_F2);
    clr_cm  = clr_rd && (rd_addr == ADDR_CM);
    clr_f1b = clr_rd && (rd_addr == ADDR_F1B_LO);
    clr_f2b = clr_rd && (rd_addr == ADDR_F2B_LO);
    clr_sat = clr_rd && (rd_addr == ADDR_STATUS);
  end

  pd_sat_counter #(.WIDTH(CNT_WIDTH), .INC_WIDTH(1)) u_tot_cnt (
    .clk(clk), .rstn(rstn), .inc_en(dbg2cif_e_debug_pd_total_pd_cnt_inc),
    .inc_amt(1'b1), .clr(clr_tot), .sat_clr(clr_sat), .cnt(tot_cnt), .sat(sat_vec[0]));

  pd_sat_counter #(.WIDTH(CNT_WIDTH), .INC_WIDTH(1)) u_f1_cnt (
    .clk(clk), .rstn(rstn), .inc_en(dbg2cif_e_debug_pd_field1_cnt_inc),
    .inc_amt(1'b1), .clr(clr_f1), .sat_clr(clr_sat), .cnt(f1_cnt), .sat(sat_vec[1]));

  pd_sat_counter #(.WIDTH(CNT_WIDTH), .INC_WIDTH(1)) u_f2_cnt (
    .clk(clk), .rstn(rstn), .inc_en(dbg2cif_e_debug_pd_field2_cnt_inc),
    .inc_amt(1'b1), .clr(clr_f2), .sat_clr(clr_sat), .cnt(f2_cnt), .sat(sat_vec[2]));

  pd_sat_counter #(.WIDTH(CNT_WIDTH), .INC_WIDTH(1)) u_cm_cnt (
    .clk(clk), .rstn(rstn), .inc_en(dbg2cif_e_debug_pd_capture_match_cnt_inc),
    .inc_amt(1'b1), .clr(clr_cm), .sat_clr(clr_sat), .cnt(cm_cnt), .sat(sat_vec[3]));

  pd_sat_counter #(.WIDTH(BYTE_CNT_WIDTH), .INC_WIDTH(PACKET_SIZE_WIDTH)) u_f1b_cnt (
    .clk(clk), .rstn(rstn), .inc_en(dbg2cif_e_debug_pd_field1_byte_cnt_inc),
    .inc_amt(dbg2cif_eq_debug_pd_field_byte_cnt_inc_amount),
    .clr(clr_f1b), .sat_clr(clr_sat), .cnt(f1b_cnt), .sat(sat_vec[4]));

  pd_sat_counter #(.WIDTH(BYTE_CNT_WIDTH), .INC_WIDTH(PACKET_SIZE_WIDTH)) u_f2b_cnt (
    .clk(clk), .rstn(rstn), .inc_en(dbg2cif_e_debug_pd_field2_byte_cnt_inc),
    .inc_amt(dbg2cif_eq_debug_pd_field_byte_cnt_inc_amount),
    .clr(clr_f2b), .sat_clr(clr_sat), .cnt(f2b_cnt), .sat(sat_vec[5]));

  // First match wins until rearmed; rearm takes priority over a same-cycle match.
  always_ff @(posedge clk) begin
    if (!rstn || cfg_capture_rearm) begin
      cap_valid <= 1'b0;
      cap_word  <= '0;
      cap_f1    <= 1'b0;
      cap_f2    <= 1'b0;
    end else if (dbg2cif_e_debug_pd_capture_match_cnt_inc && !cap_valid) begin
      cap_valid <= 1'b1;
      cap_word  <= dbg2cif_c_debug_pd_out;
      cap_f1    <= dbg2cif_e_debug_pd_capture_match_field1;
      cap_f2    <= dbg2cif_e_debug_pd_capture_match_field2;
    end
  end

  // Low-word reads freeze the high bits so a low/high pair is coherent.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      f1b_shadow <= '0;
      f2b_shadow <= '0;
    end else if (rd_req) begin
      if (rd_addr == ADDR_F1B_LO) f1b_shadow <= f1b_cnt[BYTE_CNT_WIDTH-1:32];
      if (rd_addr == ADDR_F2B_LO) f2b_shadow <= f2b_cnt[BYTE_CNT_WIDTH-1:32];
    end
  end

  always_comb begin
    rd_mux = '0;
    case (rd_addr)
      ADDR_TOTAL:   rd_mux = 32'(tot_cnt);
      ADDR_F1:      rd_mux = 32'(f1_cnt);
      ADDR_F2:      rd_mux = 32'(f2_cnt);
      ADDR_CM:      rd_mux = 32'(cm_cnt);
      ADDR_F1B_LO:  rd_mux = f1b_cnt[31:0];
      ADDR_F1B_HI:  rd_mux = 32'(f1b_shadow);
      ADDR_F2B_LO:  rd_mux = f2b_cnt[31:0];
      ADDR_F2B_HI:  rd_mux = 32'(f2b_shadow);
      ADDR_CAPTURE: rd_mux = cap_word;
      ADDR_STATUS: begin
        rd_mux[STAT_VALID_BIT]                     = cap_valid;
        rd_mux[STAT_F1_BIT]                        = cap_f1;
        rd_mux[STAT_F2_BIT]                        = cap_f2;
        rd_mux[STAT_SAT_LSB +: STAT_SAT_NUM]       = sat_vec;
      end
      default:      rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_ack  <= 1'b0;
      rd_data <= '0;
    end else begin
      rd_ack  <= rd_req;
      rd_data <= rd_req ? rd_mux : '0;
    end
  end

  assign capture_valid_o = cap_valid;

endmodule

// File: tb/tb_pd_debug_cnt_cif.sv
// tb_pd_debug_cnt_cif: self-checking bench for pd_debug_cnt_cif.
// Read expectations go into a scoreboard queue when the request is driven and
// are popped by a monitor when rd_ack appears.
module tb_pd_debug_cnt_cif;

  localparam int PSW = pd_debug_pkg::PACKET_SIZE_WIDTH;

  logic           clk = 1'b0;
  logic           rstn;
  logic           tot, f1, f2, cm, f1b, f2b;
  logic [PSW-1:0] amt;
  logic           cf1, cf2;
  logic [31:0]    pd_out;
  logic           clr_on_rd, rearm;
  logic           rd_req;
  logic [3:0]     rd_addr;
  logic           rd_ack;
  logic [31:0]    rd_data;
  logic           cap_valid;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic [5:0]  mask;
    int          reps;
    logic [3:0]  addr;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[8];

  always #5 clk = ~clk;

  pd_debug_cnt_cif dut (
    .clk(clk),
    .rstn(rstn),
    .dbg2cif_e_debug_pd_total_pd_cnt_inc(tot),
    .dbg2cif_e_debug_pd_field1_cnt_inc(f1),
    .dbg2cif_e_debug_pd_field2_cnt_inc(f2),
    .dbg2cif_e_debug_pd_capture_match_cnt_inc(cm),
    .dbg2cif_e_debug_pd_field1_byte_cnt_inc(f1b),
    .dbg2cif_e_debug_pd_field2_byte_cnt_inc(f2b),
    .dbg2cif_eq_debug_pd_field_byte_cnt_inc_amount(amt),
    .dbg2cif_e_debug_pd_capture_match_field1(cf1),
    .dbg2cif_e_debug_pd_capture_match_field2(cf2),
    .dbg2cif_c_debug_pd_out(pd_out),
    .cfg_clr_on_rd(clr_on_rd),
    .cfg_capture_rearm(rearm),
    .rd_req(rd_req),
    .rd_addr(rd_addr),
    .rd_ack(rd_ack),
    .rd_data(rd_data),
    .capture_valid_o(cap_valid)
  );

  // Response monitor, sampled 1ns after each rising edge.
  always @(posedge clk) begin
    #1;
    if (rd_ack) begin
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_ack got ack=1 data=%h want no ack", rd_data);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        if (rd_data !== e.exp) begin
          bad++;
          $display("FAIL rd_addr%0d got=%h want=%h", e.addr, rd_data, e.exp);
        end
      end
    end else if (rd_data !== 32'h0) begin
      total++;
      bad++;
      $display("FAIL idle_data got=%h want=00000000", rd_data);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, exp);
    end
  endtask

  task automatic idle_strobes();
    {tot, f1, f2, cm, f1b, f2b} = 6'b0;
  endtask

  // mask bits: [5]total [4]f1 [3]f2 [2]capture_match [1]f1 bytes [0]f2 bytes
  task automatic strobe(input logic [5:0] m, input logic [PSW-1:0] a, input int reps);
    for (int i = 0; i < reps; i++) begin
      @(negedge clk);
      {tot, f1, f2, cm, f1b, f2b} = m;
      amt = a;
    end
    @(negedge clk);
    idle_strobes();
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] e);
    sb_t s;
    @(negedge clk);
    idle_strobes();
    rd_req  = 1'b1;
    rd_addr = a;
    s.addr = a;
    s.exp  = e;
    sb_q.push_back(s);
  endtask

  task automatic rd_done();
    @(negedge clk);
    idle_strobes();
    rd_req = 1'b0;
    for (int i = 0; i < 8 && sb_q.size() != 0; i++) @(posedge clk);
    #2;
    if (sb_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL ack_timeout pending=%0d want=0", sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time=%0t want finish earlier", $time);
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{6'b110000, 3, 4'd1,  32'd3};
    vecs[1] = '{6'b001000, 4, 4'd2,  32'd4};
    vecs[2] = '{6'b101000, 2, 4'd0,  32'd10};
    vecs[3] = '{6'b000000, 1, 4'd3,  32'd0};
    vecs[4] = '{6'b111000, 1, 4'd2,  32'd7};
    vecs[5] = '{6'b000000, 1, 4'd12, 32'd0};
    vecs[6] = '{6'b000000, 1, 4'd9,  32'd0};
    vecs[7] = '{6'b010000, 2, 4'd1,  32'd6};

    rstn = 1'b0;
    idle_strobes();
    amt = '0; cf1 = 0; cf2 = 0; pd_out = '0;
    clr_on_rd = 0; rearm = 0; rd_req = 0; rd_addr = '0;
    repeat (3) @(negedge clk);
    check("reset_ack", {31'b0, rd_ack}, 32'd0);
    check("reset_data", rd_data, 32'd0);
    check("reset_capture_valid", {31'b0, cap_valid}, 32'd0);
    rstn = 1'b1;

    // five total strobes then read
    strobe(6'b100000, '0, 5);
    rd(4'd0, 32'd5);
    rd_done();

    foreach (vecs[i]) begin
      strobe(vecs[i].mask, '0, vecs[i].reps);
      rd(vecs[i].addr, vecs[i].exp);
      rd_done();
    end

    // byte counters and low/high shadow
    strobe(6'b000010, 14'h3FFF, 3);
    rd(4'd4, 32'h0000_BFFD);
    rd(4'd5, 32'h0);
    rd_done();
    strobe(6'b000001, 14'h0100, 1);
    strobe(6'b000011, 14'h0001, 1);
    rd(4'd6, 32'h0000_0101);
    rd(4'd7, 32'h0);
    rd(4'd4, 32'h0000_BFFE);
    rd_done();

    // saturation of the field1 byte counter
    @(negedge clk);
    force dut.u_f1b_cnt.cnt_q = 48'hFFFF_FFFF_C000;
    #1;
    release dut.u_f1b_cnt.cnt_q;
    strobe(6'b000010, 14'h3FFF, 1);
    rd(4'd9, 32'h0000_0080);
    rd(4'd4, 32'hFFFF_FFFF);
    rd(4'd5, 32'h0000_FFFF);
    rd_done();
    strobe(6'b000010, 14'h3FFF, 1);
    rd(4'd4, 32'hFFFF_FFFF);
    rd(4'd5, 32'h0000_FFFF);
    rd_done();

    // capture: first match sticks
    pd_out = 32'hA5A5_0001; cf1 = 1; cf2 = 0;
    strobe(6'b000100, '0, 1);
    pd_out = 32'h1234_5678; cf1 = 0; cf2 = 1;
    strobe(6'b000100, '0, 1);
    check("capture_valid_set", {31'b0, cap_valid}, 32'd1);
    rd(4'd8, 32'hA5A5_0001);
    rd(4'd3, 32'd2);
    rd(4'd9, 32'h0000_0083);
    rd_done();

    // rearm coinciding with a match: rearm wins
    @(negedge clk);
    rearm = 1; cm = 1; pd_out = 32'hDEAD_BEEF; cf1 = 1; cf2 = 1;
    @(negedge clk);
    rearm = 0; cm = 0;
    check("capture_valid_rearm", {31'b0, cap_valid}, 32'd0);
    rd(4'd8, 32'h0);
    rd(4'd9, 32'h0000_0080);
    rd_done();
    pd_out = 32'h1234_5678; cf1 = 0; cf2 = 1;
    strobe(6'b000100, '0, 1);
    rd(4'd8, 32'h1234_5678);
    rd(4'd3, 32'd4);
    rd(4'd9, 32'h0000_0085);
    rd_done();

    // clear-on-read
    clr_on_rd = 1;
    strobe(6'b010000, '0, 1);
    begin
      sb_t s;
      @(negedge clk);
      f1 = 1; rd_req = 1; rd_addr = 4'd1;
      s.addr = 4'd1; s.exp = 32'd7;
      sb_q.push_back(s);
    end
    rd(4'd1, 32'd1);
    rd(4'd1, 32'd0);
    rd(4'd9, 32'h0000_0085);
    rd(4'd9, 32'h0000_0005);
    rd(4'd4, 32'hFFFF_FFFF);
    rd(4'd5, 32'h0000_FFFF);
    rd(4'd5, 32'h0000_FFFF);
    rd(4'd4, 32'h0);
    rd(4'd5, 32'h0);
    rd(4'd0, 32'd11);
    rd(4'd0, 32'd0);
    rd(4'd8, 32'h1234_5678);
    rd(4'd8, 32'h1234_5678);
    rd_done();
    clr_on_rd = 0;

    // reset arriving with a read request
    @(negedge clk);
    rd_req = 1; rd_addr = 4'd2; rstn = 0;
    @(posedge clk);
    #1;
    check("reset_suppresses_ack", {31'b0, rd_ack}, 32'd0);
    @(negedge clk);
    rd_req = 0;
    repeat (2) @(negedge clk);
    rstn = 1;
    check("capture_valid_after_reset", {31'b0, cap_valid}, 32'd0);
    for (int a = 0; a < 16; a++) rd(4'(a), 32'h0);
    rd_done();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
